// File: rtl/packet_framer_pkg.sv
// Shared types for the packet framer: the state encoding, the I/Q sample view
// and a helper that packs an I/Q pair into a word of any half-width.
package packet_framer_pkg;

    typedef enum logic [2:0] {
        FILL,
        SYNC,
        PAD_PRE,
        HEADER,
        PAYLOAD,
        PAD_POST
    } state_t;

    // Half-width of the default 32-bit sample.
    localparam int IQ_HALF = 16;

    typedef struct packed {
        logic [IQ_HALF-1:0] i;
        logic [IQ_HALF-1:0] q;
    } iq_t;

    // Packs {I, Q} with each component truncated to 'half' bits; callers keep the
    // low 2*half bits of the result.
    function automatic logic [63:0] make_iq(input logic [31:0] i_val,
                                            input logic [31:0] q_val,
                                            input int          half);
        logic [63:0] mask;
        mask = (64'd1 << half) - 64'd1;
        return (({32'd0, i_val} & mask) << half) | ({32'd0, q_val} & mask);
    endfunction

endpackage

// File: rtl/packet_framer_buf.sv
// Payload store for one burst: NUM_DATA words written in order, with the
// slots beyond the final write cleared so a short packet reads back as zeros.
module packet_framer_buf #(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_DATA   = 4,
    localparam int AW         = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1,
    localparam int CW         = $clog2(NUM_DATA + 1)
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  zero_fill,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CW-1:0]         wr_count
);

    logic [CW-1:0]         wr_reg;
    logic [DATA_WIDTH-1:0] slot [NUM_DATA];

    // Write pointer doubles as the count of words accepted this fill.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            wr_reg <= '0;
        end else if (wr_en && (wr_reg < CW'(NUM_DATA))) begin
            wr_reg <= wr_reg + CW'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_DATA; gi++) begin : g_slot
        logic [DATA_WIDTH-1:0] slot_reg;

        // Capture the word addressed by the pointer; zero-fill clears every slot past it.
        always_ff @(posedge clk) begin
            if (srst) begin
                slot_reg <= '0;
            end else if (wr_en && (wr_reg == CW'(gi))) begin
                slot_reg <= wr_data;
            end else if (zero_fill && (CW'(gi) > wr_reg)) begin
                slot_reg <= '0;
            end
        end

        assign slot[gi] = slot_reg;
    end

    // Combinational read mux.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_DATA; k++) begin
            if (rd_addr == AW'(k)) begin
                rd_data = slot[k];
            end
        end
    end

    assign wr_count = wr_reg;

endmodule

// File: rtl/packet_framer.sv
// Packet framer: buffers NUM_DATA payload words, then emits one burst of
// SYNC preamble, PAD_PRE zeros, optional HEADER, PAYLOAD and PAD_POST zeros,
// each symbol held for NUM_SAMPLES beats, with full output backpressure.
// Optional header symbol enabled by defining PACKET_FRAMER_HEADER_EN.
module packet_framer
    import packet_framer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SAMPLES = 100,
    parameter int NUM_DATA    = 4,
    parameter int SYNC_SYMS   = 4,
    parameter int PAD_SYMS    = 4,
    parameter int AMP         = 32767
) (
    input  logic                    s00_axis_aclk,
    input  logic                    s00_axis_areset,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic                    s00_axis_tvalid,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic                    m00_axis_tvalid,
    output logic                    m00_axis_tlast,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    input  logic                    m00_axis_tready
);

    localparam int HALF = DATA_WIDTH / 2;
    localparam int MAX1 = (SYNC_SYMS > PAD_SYMS) ? SYNC_SYMS : PAD_SYMS;
    localparam int MAXS = (MAX1 > NUM_DATA) ? MAX1 : NUM_DATA;
    localparam int SW   = (MAXS > 1) ? $clog2(MAXS) : 1;
    localparam int BW   = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int AW   = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1;
    localparam int CW   = $clog2(NUM_DATA + 1);

    localparam logic [DATA_WIDTH-1:0] P0 = DATA_WIDTH'(make_iq(32'(AMP), 32'd0, HALF));
    localparam logic [DATA_WIDTH-1:0] P1 = DATA_WIDTH'(make_iq(32'd0, 32'(AMP), HALF));

`ifdef PACKET_FRAMER_HEADER_EN
    localparam state_t AFTER_PRE = HEADER;
`else
    localparam state_t AFTER_PRE = PAYLOAD;
`endif

    wire clk  = s00_axis_aclk;
    wire srst = s00_axis_areset;

    state_t                state_reg;
    logic [SW-1:0]         sym_reg;
    logic [BW-1:0]         beat_reg;
    logic                  s_ready_reg;
    logic [DATA_WIDTH-1:0] m_data_reg;
    logic                  m_valid_reg;
    logic                  m_last_reg;

    // Position of the beat about to be loaded and where the sequence goes after it.
    state_t                cur_state, nxt_state;
    logic [SW-1:0]         cur_sym, nxt_sym;
    logic [BW-1:0]         cur_beat, nxt_beat;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  beat_last;
    logic                  beat_wrap, sym_wrap, final_state;

    logic [DATA_WIDTH-1:0] rd_data;
    logic [CW-1:0]         wr_count;

    wire hs_in       = s00_axis_tvalid && s_ready_reg;
    wire last_in     = hs_in && (s00_axis_tlast || (wr_count == CW'(NUM_DATA - 1)));
    wire adv         = !m_valid_reg || m00_axis_tready;
    wire done_accept = (state_reg != FILL) && m_valid_reg && m_last_reg && m00_axis_tready;

`ifdef PACKET_FRAMER_HEADER_EN
    logic [HALF-1:0] seq_reg;

    // Burst sequence number, stepped as each burst's final beat is taken.
    always_ff @(posedge clk) begin
        if (srst) begin
            seq_reg <= '0;
        end else if (done_accept) begin
            seq_reg <= seq_reg + HALF'(1);
        end
    end
`endif

    function automatic int sym_count(input state_t st);
        case (st)
            SYNC:              return SYNC_SYMS;
            PAD_PRE, PAD_POST: return PAD_SYMS;
`ifdef PACKET_FRAMER_HEADER_EN
            HEADER:            return 1;
`endif
            PAYLOAD:           return NUM_DATA;
            default:           return 1;
        endcase
    endfunction

    // Successor of a state once its symbols are done; empty pad states are skipped.
    function automatic state_t follow(input state_t st);
        case (st)
            SYNC:    return (PAD_SYMS > 0) ? PAD_PRE : AFTER_PRE;
            PAD_PRE: return AFTER_PRE;
`ifdef PACKET_FRAMER_HEADER_EN
            HEADER:  return PAYLOAD;
`endif
            PAYLOAD: return (PAD_SYMS > 0) ? PAD_POST : PAYLOAD;
            default: return st;
        endcase
    endfunction

    packet_framer_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_DATA   (NUM_DATA)
    ) u_buf (
        .clk       (clk),
        .srst      (srst),
        .clear     (done_accept),
        .wr_en     (hs_in),
        .wr_data   (s00_axis_tdata),
        .zero_fill (last_in),
        .rd_addr   (AW'(cur_sym)),
        .rd_data   (rd_data),
        .wr_count  (wr_count)
    );

    // Beat generator: from FILL the first beat is the start of SYNC so it can be
    // loaded on the same edge as the final input handshake.
    always_comb begin
        cur_state = state_reg;
        cur_sym   = sym_reg;
        cur_beat  = beat_reg;
        if (state_reg == FILL) begin
            cur_state = SYNC;
            cur_sym   = '0;
            cur_beat  = '0;
        end

        beat_data = '0;
        case (cur_state)
            SYNC:    beat_data = cur_sym[0] ? P1 : P0;
            PAYLOAD: beat_data = rd_data;
`ifdef PACKET_FRAMER_HEADER_EN
            HEADER:  beat_data = {seq_reg, HALF'(wr_count)};
`endif
            default: beat_data = '0;
        endcase

        beat_wrap   = (cur_beat == BW'(NUM_SAMPLES - 1));
        sym_wrap    = (cur_sym == SW'(sym_count(cur_state) - 1));
        final_state = (cur_state == PAD_POST) || ((cur_state == PAYLOAD) && (PAD_SYMS == 0));
        beat_last   = beat_wrap && sym_wrap && final_state;

        nxt_state = cur_state;
        nxt_sym   = cur_sym;
        nxt_beat  = cur_beat + BW'(1);
        if (beat_wrap) begin
            nxt_beat = '0;
            if (sym_wrap) begin
                nxt_sym   = '0;
                nxt_state = follow(cur_state);
            end else begin
                nxt_sym = cur_sym + SW'(1);
            end
        end
    end

    // Framing FSM with registered AXIS outputs; the output register only reloads when empty or accepted.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg   <= FILL;
            sym_reg     <= '0;
            beat_reg    <= '0;
            s_ready_reg <= 1'b1;
            m_data_reg  <= '0;
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
        end else if (state_reg == FILL) begin
            if (last_in) begin
                s_ready_reg <= 1'b0;
                m_data_reg  <= beat_data;
                m_valid_reg <= 1'b1;
                m_last_reg  <= beat_last;
                state_reg   <= nxt_state;
                sym_reg     <= nxt_sym;
                beat_reg    <= nxt_beat;
            end
        end else if (adv) begin
            if (m_valid_reg && m_last_reg) begin
                state_reg   <= FILL;
                sym_reg     <= '0;
                beat_reg    <= '0;
                s_ready_reg <= 1'b1;
                m_data_reg  <= '0;
                m_valid_reg <= 1'b0;
                m_last_reg  <= 1'b0;
            end else begin
                m_data_reg  <= beat_data;
                m_valid_reg <= 1'b1;
                m_last_reg  <= beat_last;
                state_reg   <= nxt_state;
                sym_reg     <= nxt_sym;
                beat_reg    <= nxt_beat;
            end
        end
    end

    assign s00_axis_tready = s_ready_reg;
    assign m00_axis_tdata  = m_data_reg;
    assign m00_axis_tvalid = m_valid_reg;
    assign m00_axis_tlast  = m_last_reg;
    assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_packet_framer.sv
// Directed bench for packet_framer with NUM_SAMPLES=2, NUM_DATA=2, SYNC_SYMS=2,
// PAD_SYMS=1, AMP=100. Header beats are expected when PACKET_FRAMER_HEADER_EN is defined.
module tb_packet_framer;

`ifdef PACKET_FRAMER_HEADER_EN
    localparam int NB = 14;
`else
    localparam int NB = 12;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_ready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [3:0]  m_tstrb;
    logic        m_tready;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_beats [16];
    logic [15:0] bseq;

    packet_framer #(
        .DATA_WIDTH  (32),
        .NUM_SAMPLES (2),
        .NUM_DATA    (2),
        .SYNC_SYMS   (2),
        .PAD_SYMS    (1),
        .AMP         (100)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tready (s_ready),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tready (m_tready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected burst for payload words a, b; 'words' is the fill count carried in the header.
    task automatic set_exp(input logic [31:0] a, input logic [31:0] b, input int words);
        int k;
        exp_beats[0] = 32'h00640000;
        exp_beats[1] = 32'h00640000;
        exp_beats[2] = 32'h00000064;
        exp_beats[3] = 32'h00000064;
        exp_beats[4] = 32'h0;
        exp_beats[5] = 32'h0;
        k = 6;
`ifdef PACKET_FRAMER_HEADER_EN
        exp_beats[6] = {bseq, 16'(words)};
        exp_beats[7] = {bseq, 16'(words)};
        k = 8;
`endif
        exp_beats[k]   = a;
        exp_beats[k+1] = a;
        exp_beats[k+2] = b;
        exp_beats[k+3] = b;
        exp_beats[k+4] = 32'h0;
        exp_beats[k+5] = 32'h0;
    endtask

    // Offer one input word and wait (bounded) for its handshake.
    task automatic send(input logic [31:0] word, input logic last);
        int w;
        s_tdata  = word;
        s_tlast  = last;
        s_tvalid = 1'b1;
        w = 0;
        while (s_ready !== 1'b1 && w < 200) begin
            tick();
            w++;
        end
        chk("send_ready", {31'd0, s_ready}, 32'd1);
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        $display("in  word %h last %b", word, last);
    endtask

    // Check beats [start, stop) with tready held high; a complete burst also checks the return to FILL.
    task automatic get_burst(input int start, input int stop, input string tag);
        for (int i = start; i < stop; i++) begin
            chk({tag, "_tvalid"}, {31'd0, m_tvalid}, 32'd1);
            chk({tag, "_tdata"}, m_tdata, exp_beats[i]);
            chk({tag, "_tlast"}, {31'd0, m_tlast}, (i == NB - 1) ? 32'd1 : 32'd0);
            chk({tag, "_sready_low"}, {31'd0, s_ready}, 32'd0);
            $display("out beat %0d data %h last %b", i, m_tdata, m_tlast);
            tick();
        end
        if (stop == NB) begin
            chk({tag, "_end_tvalid"}, {31'd0, m_tvalid}, 32'd0);
            chk({tag, "_end_sready"}, {31'd0, s_ready}, 32'd1);
            bseq = bseq + 16'd1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        bseq     = 16'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_sready", {31'd0, s_ready}, 32'd1);
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("tstrb", {28'd0, m_tstrb}, 32'hF);

        // 1: full burst
        set_exp(32'hAAAA5555, 32'h12345678, 2);
        send(32'hAAAA5555, 1'b0);
        chk("t1_mid_sready", {31'd0, s_ready}, 32'd1);
        send(32'h12345678, 1'b0);
        chk("t1_first_valid", {31'd0, m_tvalid}, 32'd1);
        get_burst(0, NB, "t1");

        // 2: early tlast zero-fills the second payload word
        set_exp(32'hDEADBEEF, 32'h0, 1);
        send(32'hDEADBEEF, 1'b1);
        chk("t2_sready_drop", {31'd0, s_ready}, 32'd0);
        get_burst(0, NB, "t2");

        // 3: backpressure for 5 cycles mid-SYNC
        set_exp(32'h0BADF00D, 32'hCAFE0001, 2);
        send(32'h0BADF00D, 1'b0);
        send(32'hCAFE0001, 1'b0);
        get_burst(0, 1, "t3a");
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_hold_tvalid", {31'd0, m_tvalid}, 32'd1);
            chk("t3_hold_tdata", m_tdata, exp_beats[1]);
            chk("t3_hold_tlast", {31'd0, m_tlast}, 32'd0);
        end
        m_tready = 1'b1;
        get_burst(1, NB, "t3b");

        // 4: second packet offered during a burst is held off until FILL
        set_exp(32'h11112222, 32'h33334444, 2);
        send(32'h11112222, 1'b0);
        send(32'h33334444, 1'b0);
        s_tdata  = 32'h55556666;
        s_tvalid = 1'b1;
        get_burst(0, NB, "t4a");
        set_exp(32'h55556666, 32'h77778888, 2);
        send(32'h55556666, 1'b0);
        send(32'h77778888, 1'b0);
        get_burst(0, NB, "t4b");

        // 5: reset mid-PAYLOAD abandons the burst
        set_exp(32'h01010101, 32'h02020202, 2);
        send(32'h01010101, 1'b0);
        send(32'h02020202, 1'b0);
        get_burst(0, NB - 5, "t5a");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bseq = 16'd0;
        chk("t5_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("t5_tlast", {31'd0, m_tlast}, 32'd0);
        chk("t5_sready", {31'd0, s_ready}, 32'd1);
        set_exp(32'hA5A5A5A5, 32'h5A5A5A5A, 2);
        send(32'hA5A5A5A5, 1'b0);
        send(32'h5A5A5A5A, 1'b0);
        get_burst(0, NB, "t5b");

        // 6: two bursts from a fresh reset (header values when enabled)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bseq = 16'd0;
        set_exp(32'h00C0FFEE, 32'h00BEEF00, 2);
`ifdef PACKET_FRAMER_HEADER_EN
        exp_beats[6] = 32'h00000002;
        exp_beats[7] = 32'h00000002;
`endif
        send(32'h00C0FFEE, 1'b0);
        send(32'h00BEEF00, 1'b0);
        get_burst(0, NB, "t6a");
        set_exp(32'h76543210, 32'h0, 1);
`ifdef PACKET_FRAMER_HEADER_EN
        exp_beats[6] = 32'h00010001;
        exp_beats[7] = 32'h00010001;
`endif
        send(32'h76543210, 1'b1);
        get_burst(0, NB, "t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
